wb_regfile: RTL and testbench

- Write-back stage plus architectural integer register file for the 5-stage RISC core.
- Consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32x32 register file.
- Serves the two decode-stage read ports with same-cycle write-through bypass, a debug read port, and a retired-instruction counter.

---
 rtl/core_pkg.sv | 14 +
 rtl/regfile_2r1w.sv | 69 ++++++
 rtl/wb_regfile.sv | 73 +++++++
 tb/tb_wb_regfile.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants and encodings.
// Used by the write-back stage and register file.
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry integer register file, 2 read / 1 write.
// x0 is hardwired to zero; reads bypass the same-cycle write.
module regfile_2r1w
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 res,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [XLEN-1:0]      wd,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Next array state: apply the single write, never to x0
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != REG_ZERO)) begin
      regs_d[wa] = wd;
    end
  end

  // Array storage, cleared asynchronously
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: zero in reset or for x0, else bypass or array
  always_comb begin
    rd1 = regs_q[ra1];
    if (!res || (ra1 == REG_ZERO)) begin
      rd1 = '0;
    end else if (we && (ra1 == wa)) begin
      rd1 = wd;
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rd2 = regs_q[ra2];
    if (!res || (ra2 == REG_ZERO)) begin
      rd2 = '0;
    end else if (we && (ra2 == wa)) begin
      rd2 = wd;
    end
  end

  // Debug port sees committed state only
  always_comb begin
    dbg_data = regs_q[dbg_addr];
    if (!res || (dbg_addr == REG_ZERO)) begin
      dbg_data = '0;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, valid gating,
// register-file commit and retire counter.
module wb_regfile
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 wb_valid,
  input  logic [XLEN-1:0]      data_in,
  input  logic [XLEN-1:0]      alu_in,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic                 RegWrite_WB_in,
  input  logic                 MemtoReg_WB_in,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]      dbg_data,
  output logic [XLEN-1:0]      wb_data,
  output logic [CNT_W-1:0]     retire_cnt
);

  logic             we;
  logic [CNT_W-1:0] retire_cnt_q;
  logic [CNT_W-1:0] retire_cnt_d;

  // Result select; bubbles force zero so junk never leaks
  always_comb begin
    wb_data = '0;
    if (wb_valid) begin
      wb_data = (MemtoReg_WB_in == WB_SEL_MEM) ? data_in : alu_in;
    end
  end

  // Commit enable: valid, write requested, not x0
  always_comb begin
    we = wb_valid & RegWrite_WB_in & (rd_in != REG_ZERO);
  end

  // Every valid entry retires, writing or not; wraps silently
  always_comb begin
    retire_cnt_d = retire_cnt_q + CNT_W'(wb_valid);
  end

  // Retire counter register
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

  regfile_2r1w u_rf (
    .clk      (clk),
    .res      (res),
    .we       (we),
    .wa       (rd_in),
    .wd       (wb_data),
    .ra1      (rs1_addr),
    .ra2      (rs2_addr),
    .rd1      (rs1_data),
    .rd2      (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile.
// Second instance uses a 4-bit counter to reach wrap.
module tb_wb_regfile;

  logic        clk;
  logic        res;
  logic        wb_valid;
  logic [31:0] data_in;
  logic [31:0] alu_in;
  logic [4:0]  rd_in;
  logic        RegWrite_WB_in;
  logic        MemtoReg_WB_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] dbg_data;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  logic [31:0] rs1_data4;
  logic [31:0] rs2_data4;
  logic [31:0] dbg_data4;
  logic [31:0] wb_data4;
  logic [3:0]  retire_cnt4;

  int n_run;
  int n_fail;

  wb_regfile #(.CNT_W(32)) u_dut (
    .clk            (clk),
    .res            (res),
    .wb_valid       (wb_valid),
    .data_in        (data_in),
    .alu_in         (alu_in),
    .rd_in          (rd_in),
    .RegWrite_WB_in (RegWrite_WB_in),
    .MemtoReg_WB_in (MemtoReg_WB_in),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data),
    .wb_data        (wb_data),
    .retire_cnt     (retire_cnt)
  );

  wb_regfile #(.CNT_W(4)) u_dut4 (
    .clk            (clk),
    .res            (res),
    .wb_valid       (wb_valid),
    .data_in        (data_in),
    .alu_in         (alu_in),
    .rd_in          (rd_in),
    .RegWrite_WB_in (RegWrite_WB_in),
    .MemtoReg_WB_in (MemtoReg_WB_in),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (rs1_data4),
    .rs2_data       (rs2_data4),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data4),
    .wb_data        (wb_data4),
    .retire_cnt     (retire_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw,
                       input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu,
                       input logic [31:0] dat);
    wb_valid       = v;
    RegWrite_WB_in = rw;
    MemtoReg_WB_in = m2r;
    rd_in          = rd;
    alu_in         = alu;
    data_in        = dat;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    res    = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd5, $urandom, $urandom);
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    dbg_addr = 5'd1;
    tick();
    tick();
    chk("rst_rs1_nobyp", rs1_data, 32'h0);
    chk("rst_rs2", rs2_data, 32'h0);
    chk("rst_cnt", retire_cnt, 32'h0);

    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    res = 1'b1;
    tick();
    chk("rel_rs1", rs1_data, 32'h0);
    chk("rel_rs2", rs2_data, 32'h0);
    chk("rel_dbg", dbg_data, 32'h0);
    chk("rel_cnt", retire_cnt, 32'h0);

    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0);
    rs1_addr = 5'd7;
    dbg_addr = 5'd7;
    #1;
    chk("alu_byp", rs1_data, 32'hDEADBEEF);
    chk("alu_wbd", wb_data, 32'hDEADBEEF);
    chk("alu_dbg_pre", dbg_data, 32'h0);
    tick();
    chk("alu_dbg_post", dbg_data, 32'hDEADBEEF);
    chk("alu_cnt", retire_cnt, 32'd1);

    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0, 32'h12345678);
    dbg_addr = 5'd3;
    #1;
    chk("ld_wbd", wb_data, 32'h12345678);
    tick();
    chk("ld_x3", dbg_data, 32'h12345678);

    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
    rs1_addr = 5'd0;
    dbg_addr = 5'd0;
    #1;
    chk("x0_same", rs1_data, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("x0_next", rs1_data, 32'h0);
    chk("x0_dbg", dbg_data, 32'h0);
    chk("x0_cnt", retire_cnt, 32'd3);

    drive(1'b0, 1'b1, $urandom, 5'd3, $urandom, $urandom);
    rs1_addr = 5'd3;
    dbg_addr = 5'd3;
    #1;
    chk("bub_wbd", wb_data, 32'h0);
    chk("bub_rs1", rs1_data, 32'h12345678);
    tick();
    chk("bub_x3", dbg_data, 32'h12345678);
    chk("bub_cnt", retire_cnt, 32'd3);

    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hA5A5A5A5, 32'h0);
    rs1_addr = 5'd9;
    rs2_addr = 5'd9;
    dbg_addr = 5'd9;
    #1;
    chk("dual_rs1", rs1_data, 32'hA5A5A5A5);
    chk("dual_rs2", rs2_data, 32'hA5A5A5A5);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h11111111, 32'h0);
    #1;
    chk("nowr_rs1", rs1_data, 32'hA5A5A5A5);
    tick();
    chk("nowr_x9", dbg_data, 32'hA5A5A5A5);
    chk("nowr_cnt", retire_cnt, 32'd5);

    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'hCAFEF00D, 32'h0);
    rs1_addr = 5'd4;
    dbg_addr = 5'd4;
    #1;
    res = 1'b0;
    tick();
    chk("midrst_dbg", dbg_data, 32'h0);
    chk("midrst_x9", rs2_data, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    res = 1'b1;
    tick();
    chk("midrst_x4", dbg_data, 32'h0);
    chk("midrst_rs1", rs1_data, 32'h0);
    chk("midrst_cnt", retire_cnt, 32'h0);

    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("wrap_pre4", {28'h0, retire_cnt4}, 32'd15);
    chk("wrap_pre32", retire_cnt, 32'd15);
    tick();
    chk("wrap_post4", {28'h0, retire_cnt4}, 32'd0);
    chk("wrap_post32", retire_cnt, 32'd16);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("wrap_hold4", {28'h0, retire_cnt4}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
